// File: rtl/program3_pkg.sv
// Shared defaults and word type for the program3 register-file slice.
package program3_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

    typedef logic [DEF_DATA_W-1:0] word_t;

endpackage : program3_pkg

// File: rtl/program3_mem.sv
// Word storage array: synchronous write and clear, asynchronous read.
// One shared address serves both the write and the read port.
module program3_mem
    import program3_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear wins over write; otherwise store wdata at the addressed word.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read is combinational so the stored word is visible in the same cycle.
    assign rdata = mem[addr];

endmodule : program3_mem

// File: rtl/program3.sv
// Top of the program3 slice: reset/write priority and load gating around
// the storage array. The read path shows the stored word only, never d_in.
module program3
    import program3_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              c,
    input  logic              rst,
    input  logic              str,
    input  logic              ld,
    input  logic [DATA_W-1:0] d_in,
    input  logic [ADDR_W-1:0] a,
    output logic [DATA_W-1:0] d
);

    logic              wr_en;
    logic [DATA_W-1:0] rd_word;

    // A write coinciding with reset is discarded.
    always_comb begin
        wr_en = str & ~rst;
    end

    program3_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (c),
        .clr   (rst),
        .we    (wr_en),
        .addr  (a),
        .wdata (d_in),
        .rdata (rd_word)
    );

    // Drive zeros rather than the array contents when no load is requested.
    always_comb begin
        d = ld ? rd_word : '0;
    end

endmodule : program3

// File: tb/tb_program3.sv
// Directed self-checking bench for program3.
module tb_program3;
    import program3_pkg::*;

    logic        c;
    logic        rst;
    logic        str;
    logic        ld;
    word_t       d_in;
    logic [3:0]  a;
    word_t       d;

    int total;
    int bad;

    program3 dut (
        .c    (c),
        .rst  (rst),
        .str  (str),
        .ld   (ld),
        .d_in (d_in),
        .a    (a),
        .d    (d)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic check_eq(input string tag, input word_t obs, input word_t exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance to one unit after the next rising edge.
    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic write_word(input int addr, input word_t val);
        a    = 4'(addr);
        d_in = val;
        str  = 1'b1;
        tick();
        str  = 1'b0;
    endtask

    task automatic read_expect(input string tag, input int addr, input word_t exp);
        a = 4'(addr);
        #1;
        check_eq($sformatf("%s[%0d]", tag, addr), d, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        str   = 1'b0;
        ld    = 1'b0;
        d_in  = '0;
        a     = '0;
        tick();
        tick();

        // Reset state
        check_eq("rst_ld0", d, 32'h0);
        ld = 1'b1;
        read_expect("rst_rd", 0, 32'h0);
        read_expect("rst_rd", 15, 32'h0);
        ld  = 1'b0;
        rst = 1'b0;
        tick();

        // Fill: address i-1 gets i
        for (int i = 1; i <= 16; i++) write_word(i - 1, word_t'(i));
        ld = 1'b1;
        for (int i = 0; i < 16; i++) read_expect("fill", i, word_t'(i + 1));

        // Load gating
        ld = 1'b0;
        a  = 4'd9;
        #1;
        check_eq("ld0_zero", d, 32'h0);
        ld = 1'b1;
        read_expect("ld1", 5, 32'h6);

        // No write with str=0
        str  = 1'b0;
        d_in = 32'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            tick();
        end
        for (int i = 0; i < 16; i++) read_expect("nowr", i, word_t'(i + 1));

        // Same-address write while loading: old before edge, new after
        tick();
        a    = 4'd3;
        str  = 1'b1;
        d_in = 32'hAAAA_5555;
        #1;
        check_eq("wr_before", d, 32'h4);
        tick();
        check_eq("wr_after", d, 32'hAAAA_5555);
        str = 1'b0;
        read_expect("neighbor", 4, 32'h5);

        // Reset with a coinciding write
        a    = 4'd7;
        d_in = 32'h1234_5678;
        str  = 1'b1;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        str = 1'b0;
        for (int i = 0; i < 16; i++) read_expect("rstwr", i, 32'h0);

        // Reset midway through a fill, then resume
        for (int i = 0; i < 8; i++) write_word(i, word_t'(i + 1));
        read_expect("mid_pre", 7, 32'h8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 8; i < 16; i++) write_word(i, word_t'(i + 1));
        for (int i = 0; i < 8; i++)  read_expect("mid_lo", i, 32'h0);
        for (int i = 8; i < 16; i++) read_expect("mid_hi", i, word_t'(i + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_program3

// File: doc/program3.md
PROGRAM3 -- requirements
Module: program3

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the word width in bits.
REQ-002 Parameter ADDR_W, default 4, SHALL set the address width in bits.
REQ-003 Parameter DEPTH, default 2**ADDR_W (16), SHALL set the number of stored words.
REQ-004 c  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be the reset; reset is synchronous and active-high.
REQ-006 str  input  1  SHALL be the store (write) enable, active-high.
REQ-007 ld  input  1  SHALL be the load (read) enable, active-high.
REQ-008 d_in  input  DATA_W  SHALL be the write data.
REQ-009 a  input  ADDR_W  SHALL be the shared read/write word address.
REQ-010 d  output  DATA_W  SHALL be the read data.

Function
REQ-011 The block SHALL hold DEPTH words of DATA_W bits, indexed 0..DEPTH-1 by a.
REQ-012 Write: at a rising edge of c with rst=0 and str=1, mem[a] SHALL take the value of d_in sampled at that edge.
REQ-013 No write SHALL occur at any edge where str=0.
REQ-014 Read SHALL be asynchronous (combinational): with ld=1, d SHALL equal mem[a] within the same cycle, with no clock latency.
REQ-015 With ld=0, d SHALL be driven to all zeros, not high-impedance.
REQ-016 A change of a with ld=1 SHALL update d combinationally, without waiting for a clock edge.
REQ-017 str=1 and ld=1 to the same address: before the edge, d SHALL show the old word; after the edge, d SHALL show the newly written word. No write-through bypass of d_in to d.
REQ-018 str=1 and ld=1 to different addresses: the write SHALL NOT disturb the read of the other address.
REQ-019 d_in wider than the word is impossible; addresses SHALL need no range check (DEPTH = 2**ADDR_W fills the space).
REQ-020 Outputs SHALL be free of X after the first reset, for every address.

Reset
REQ-021 At a rising edge of c with rst=1, all DEPTH words SHALL be cleared to 0.
REQ-022 rst SHALL have priority over str; a write coinciding with reset SHALL be discarded.
REQ-023 d SHALL follow REQ-014/REQ-015 during reset: 0 when ld=0, and the cleared contents (0) when ld=1 after the reset edge.
REQ-024 Reset asserted in the middle of a write sequence SHALL leave all words 0; writes after rst deasserts SHALL proceed normally.

Structure
REQ-025 DATA_W, ADDR_W and DEPTH defaults SHALL live in a shared package (program3_pkg) together with a word typedef of width DATA_W.
REQ-026 The storage array with sync write and async read port SHALL be one sub-module, program3_mem; the top SHALL contain the reset/priority logic and the ld output gating.
REQ-027 The design SHALL be synthesizable as distributed/LUT RAM or flops (async read); no vendor primitives.

Verification
REQ-028 Reset, then write d_in=i to address i-1 for i=1..16 (str=1, one word per cycle), then ld=1 and sweep a=0..15 -> d = a+1 (1h..10h) within 1 time unit of each address change.
REQ-029 After REQ-028 fill, ld=0 with any a -> d=0; ld=1, a=5 -> d=6h.
REQ-030 After fill, str=0, d_in=FFFFFFFFh, clock 16 cycles over all addresses -> readback unchanged (a+1).
REQ-031 ld=1, a=3 holding 4h, str=1, d_in=AAAA5555h -> d=4h before the edge, AAAA5555h after it; a=4 still reads 5h.
REQ-032 After fill, assert rst=1 for one cycle with str=1, d_in=12345678h, a=7 -> every address reads 0, including 7.
REQ-033 Assert rst midway through the fill (after address 7), then resume writes 8..15 -> addresses 0..7 read 0 and 8..15 read a+1.
